fifo_rd_arbiter: RTL and testbench

Read-side scheduler for the async FIFO, living entirely in the read clock domain. Shares the FIFO read port between NUM_REQ consumers in fixed-length bursts with round-robin fairness. Drives the FIFO read enable from the FIFO `empty` flag and consumer backpressure, and tags returned words with the owner ID. An empty-stall timeout keeps one requester from holding the port while the FIFO is starved.

---
 rtl/fifo_arb_pkg.sv | 30 +++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/fifo_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared state encoding, default sizing and width helpers for the FIFO
// read-port arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int TIMEOUT_DEF   = 16;

  // Index width for n items; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold every value 0..maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal > 0) ? $clog2(maxVal + 1) : 1;
  endfunction

  localparam int ID_W_DEF    = idxWidth(NUM_REQ_DEF);
  localparam int BEAT_W_DEF  = cntWidth(BURST_LEN_DEF);
  localparam int STALL_W_DEF = cntWidth(TIMEOUT_DEF);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request searching upward
// from lastOwner_i+1 with wrap-around.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    lastOwner_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               valid_o
);

  logic [ID_W-1:0] candIdx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    candIdx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      candIdx = ID_W'((int'(lastOwner_i) + i) % NUM_REQ);
      if (req_i[candIdx]) begin
        winner_o = candIdx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side FIFO scheduler: grants the read port to one consumer at a time
// in fixed bursts, round-robin, with an empty-stall timeout.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ   = NUM_REQ_DEF,
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  BURST_LEN = BURST_LEN_DEF,
  parameter int  TIMEOUT   = TIMEOUT_DEF,
  localparam int ID_W      = idxWidth(NUM_REQ)
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  input  logic               fifo_empty,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  output logic               fifo_rd_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [ID_W-1:0]    out_id,
  output logic               out_last,
  output logic               burst_done,
  output logic               burst_abort
);

  localparam int BEAT_W  = cntWidth(BURST_LEN);
  localparam int STALL_W = cntWidth(TIMEOUT);

  localparam logic [BEAT_W-1:0]  BEAT_END  = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'(TIMEOUT - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
  localparam logic [ID_W-1:0]    LAST_REQ  = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    lastOwner_q;
  logic [BEAT_W-1:0]  beatCnt_q;
  logic [STALL_W-1:0] stallCnt_q;
  logic [STALL_W-1:0] stallCnt_d;
  logic               outValid_q;
  logic [ID_W-1:0]    outId_q;
  logic               outLast_q;
  logic               burstDone_q;
  logic               burstAbort_q;
  logic [DATA_W-1:0]  dataHold_q;

  logic               rdEn;
  logic               ownerReq;
  logic               lastBeat;
  logic               stallHit;
  logic [ID_W-1:0]    pickWinner;
  logic               pickValid;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i       (req),
    .lastOwner_i (lastOwner_q),
    .winner_o    (pickWinner),
    .valid_o     (pickValid)
  );

  always_comb begin
    ownerReq   = req[owner_q];
    lastBeat   = (beatCnt_q == BEAT_LAST);
    stallHit   = (stallCnt_q == STALL_HIT);
    stallCnt_d = (stallCnt_q == STALL_MAX) ? stallCnt_q : stallCnt_q + STALL_W'(1);
    rdEn       = (state_q == BURST) && !fifo_empty && out_ready && ownerReq
                 && (beatCnt_q < BEAT_END);
  end

  // Burst FSM plus the return path; a read issued in the last BURST cycle
  // surfaces on out_valid during FLUSH.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      lastOwner_q  <= LAST_REQ;
      beatCnt_q    <= '0;
      stallCnt_q   <= '0;
      outValid_q   <= 1'b0;
      outId_q      <= '0;
      outLast_q    <= 1'b0;
      burstDone_q  <= 1'b0;
      burstAbort_q <= 1'b0;
      dataHold_q   <= '0;
    end else begin
      burstDone_q  <= 1'b0;
      burstAbort_q <= 1'b0;
      outValid_q   <= rdEn;
      outLast_q    <= rdEn && lastBeat;
      if (rdEn) begin
        outId_q <= owner_q;
      end
      if (outValid_q) begin
        dataHold_q <= fifo_rd_data;
      end

      case (state_q)
        IDLE: begin
          if (pickValid) begin
            gnt_q      <= ONE_HOT0 << pickWinner;
            owner_q    <= pickWinner;
            beatCnt_q  <= '0;
            stallCnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (rdEn) begin
            beatCnt_q  <= beatCnt_q + BEAT_W'(1);
            stallCnt_q <= '0;
            if (lastBeat) begin
              burstDone_q <= 1'b1;
              state_q     <= FLUSH;
            end
          end else begin
            stallCnt_q <= stallCnt_d;
            if (!ownerReq || stallHit) begin
              burstDone_q  <= 1'b1;
              burstAbort_q <= 1'b1;
              state_q      <= FLUSH;
            end
          end
        end
        FLUSH: begin
          gnt_q       <= '0;
          lastOwner_q <= owner_q;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FIFO data lands one cycle after the read, the same cycle out_valid rises,
  // so the live bus is forwarded then and the held copy is shown afterwards.
  assign out_data    = outValid_q ? fifo_rd_data : dataHold_q;
  assign fifo_rd_en  = rdEn;
  assign gnt         = gnt_q;
  assign out_valid   = outValid_q;
  assign out_id      = outId_q;
  assign out_last    = outLast_q;
  assign burst_done  = burstDone_q;
  assign burst_abort = burstAbort_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a table-driven two-burst sequence plus
// hand-written sequences for fairness, timeout, backpressure, drop and reset.
module tb_fifo_rd_arbiter;

  localparam int BL = 4;

  logic       rclk;
  logic       rrst_n;
  logic [3:0] req;
  logic       out_ready;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic [3:0] gnt;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_id;
  logic       out_last;
  logic       burst_done;
  logic       burst_abort;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       rdEn;
    logic [3:0] gnt;
    logic       valid;
    logic [7:0] data;
    logic [1:0] id;
    logic       last;
    logic       done;
    logic       abort;
  } vec_t;

  vec_t vecs[$];

  fifo_rd_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .BURST_LEN (BL),
    .TIMEOUT   (16)
  ) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .req          (req),
    .out_ready    (out_ready),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .gnt          (gnt),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_id       (out_id),
    .out_last     (out_last),
    .burst_done   (burst_done),
    .burst_abort  (burst_abort)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Simple FIFO model with registered read data, valid one cycle after the read.
  logic [7:0] fifoMem [0:255];
  logic [7:0] wrPtr = 8'd0;
  logic [7:0] rdPtr = 8'd0;

  assign fifo_empty = (wrPtr == rdPtr);

  always @(posedge rclk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifoMem[rdPtr];
      rdPtr        <= rdPtr + 8'd1;
    end
  end

  task automatic pushWord(input logic [7:0] d);
    fifoMem[wrPtr] = d;
    wrPtr = wrPtr + 8'd1;
  endtask

  task automatic fifoFlush();
    wrPtr = rdPtr;
  endtask

  task automatic addVec(input logic [3:0] r, input logic rdy, input logic rdEn,
                        input logic [3:0] g, input logic v, input logic [7:0] d,
                        input logic [1:0] id, input logic l, input logic dn,
                        input logic ab);
    vec_t t;
    t.req = r; t.rdy = rdy; t.rdEn = rdEn; t.gnt = g; t.valid = v;
    t.data = d; t.id = id; t.last = l; t.done = dn; t.abort = ab;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    @(negedge rclk);
    req       = r;
    out_ready = rdy;
    #1;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " gnt"},         32'(gnt),         32'h0);
    checkOutput({tag, " rd_en"},       32'(fifo_rd_en),  32'h0);
    checkOutput({tag, " out_valid"},   32'(out_valid),   32'h0);
    checkOutput({tag, " out_data"},    32'(out_data),    32'h0);
    checkOutput({tag, " out_id"},      32'(out_id),      32'h0);
    checkOutput({tag, " out_last"},    32'(out_last),    32'h0);
    checkOutput({tag, " burst_done"},  32'(burst_done),  32'h0);
    checkOutput({tag, " burst_abort"}, 32'(burst_abort), 32'h0);
  endtask

  task automatic pulseReset();
    @(negedge rclk);
    rrst_n    = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b1;
    @(negedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  task automatic waitGrant(input string tag);
    int n = 0;
    do begin
      @(negedge rclk);
      #1;
      n++;
    end while (gnt == 4'b0000 && n < 20);
    checkOutput({tag, " grant seen"}, 32'(gnt != 4'b0000), 32'h1);
  endtask

  // Follows one burst with inputs held constant, from grant through FLUSH.
  task automatic watchBurst(input string tag, input logic [3:0] expGnt,
                            input int expIdx, input int expWords,
                            input logic [7:0] firstData, input logic expAbort,
                            input int expRows);
    int rows = 0;
    int words = 0;
    int lastCnt = 0;
    waitGrant(tag);
    checkOutput({tag, " gnt"}, 32'(gnt), 32'(expGnt));
    while (rows < 60) begin
      rows++;
      if (out_valid) begin
        checkOutput($sformatf("%s word%0d data", tag, words), 32'(out_data),
                    32'(firstData + 8'(words)));
        checkOutput($sformatf("%s word%0d id", tag, words), 32'(out_id), 32'(expIdx));
        if (out_last) begin
          lastCnt++;
          checkOutput({tag, " last position"}, 32'(words), 32'(BL - 1));
        end
        words++;
      end
      if (burst_done) break;
      checkOutput({tag, " gnt stable"}, 32'(gnt), 32'(expGnt));
      @(negedge rclk);
      #1;
    end
    checkOutput({tag, " burst_done"},  32'(burst_done),  32'h1);
    checkOutput({tag, " burst_abort"}, 32'(burst_abort), 32'(expAbort));
    checkOutput({tag, " gnt at done"}, 32'(gnt),         32'(expGnt));
    checkOutput({tag, " word count"},  32'(words),       32'(expWords));
    checkOutput({tag, " last count"},  32'(lastCnt),     32'((expWords == BL) ? 1 : 0));
    checkOutput({tag, " burst rows"},  32'(rows),        32'(expRows));
    @(negedge rclk);
    #1;
    checkOutput({tag, " gnt released"}, 32'(gnt), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int words;
    rrst_n    = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pushWord(8'h10 + 8'(i));

    repeat (2) @(negedge rclk);
    #1;
    checkIdleZero("reset");
    @(negedge rclk);
    rrst_n = 1'b1;

    // Two back-to-back full bursts: owner 0 then owner 1.
    //      req    rdy  rdEn gnt    v  data   id l  dn ab
    addVec(4'h3, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h1, 0, 8'h00, 0, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h1, 1, 8'h10, 0, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h1, 1, 8'h11, 0, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h1, 1, 8'h12, 0, 0, 0, 0);
    addVec(4'h3, 1, 0, 4'h1, 1, 8'h13, 0, 1, 1, 0);
    addVec(4'h3, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h2, 0, 8'h00, 0, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h2, 1, 8'h14, 1, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h2, 1, 8'h15, 1, 0, 0, 0);
    addVec(4'h3, 1, 1, 4'h2, 1, 8'h16, 1, 0, 0, 0);
    addVec(4'h0, 1, 0, 4'h2, 1, 8'h17, 1, 1, 1, 0);
    addVec(4'h0, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].rdy);
      checkOutput($sformatf("vec%0d rd_en", i),  32'(fifo_rd_en),  32'(vecs[i].rdEn));
      checkOutput($sformatf("vec%0d gnt", i),    32'(gnt),         32'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d valid", i),  32'(out_valid),   32'(vecs[i].valid));
      if (vecs[i].valid) begin
        checkOutput($sformatf("vec%0d data", i), 32'(out_data),    32'(vecs[i].data));
        checkOutput($sformatf("vec%0d id", i),   32'(out_id),      32'(vecs[i].id));
      end
      checkOutput($sformatf("vec%0d last", i),   32'(out_last),    32'(vecs[i].last));
      checkOutput($sformatf("vec%0d done", i),   32'(burst_done),  32'(vecs[i].done));
      checkOutput($sformatf("vec%0d abort", i),  32'(burst_abort), 32'(vecs[i].abort));
    end

    // All four requesting: strict rotation 0,1,2,3,0.
    pulseReset();
    fifoFlush();
    for (int i = 0; i < 24; i++) pushWord(8'h20 + 8'(i));
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      watchBurst($sformatf("rr%0d", k), 4'(1 << (k % 4)), k % 4, 4,
                 8'h20 + 8'(4 * k), 1'b0, 5);
    end
    req = 4'b0000;

    // Starved FIFO: two words, then sixteen stall cycles and an abort.
    pulseReset();
    fifoFlush();
    pushWord(8'h30);
    pushWord(8'h31);
    req       = 4'b0100;
    out_ready = 1'b1;
    watchBurst("starve", 4'b0100, 2, 2, 8'h30, 1'b1, 19);
    req = 4'b0000;

    // Alternating backpressure: reads only while out_ready is high.
    pulseReset();
    fifoFlush();
    for (int i = 0; i < 4; i++) pushWord(8'h40 + 8'(i));
    req       = 4'b0001;
    out_ready = 1'b1;
    waitGrant("bp");
    checkOutput("bp row1 rd_en", 32'(fifo_rd_en), 32'h1);
    words = 0;
    for (int row = 2; row <= 8; row++) begin
      applyStimulus(4'b0001, (row % 2) == 1);
      if (out_valid) begin
        checkOutput($sformatf("bp word%0d", words), 32'(out_data), 32'(8'h40 + 8'(words)));
        words++;
      end
      if (row <= 7) begin
        checkOutput($sformatf("bp row%0d rd_en", row), 32'(fifo_rd_en), 32'(out_ready));
        checkOutput($sformatf("bp row%0d no done", row), 32'(burst_done), 32'h0);
      end
    end
    checkOutput("bp done",  32'(burst_done),  32'h1);
    checkOutput("bp abort", 32'(burst_abort), 32'h0);
    checkOutput("bp last",  32'(out_last),    32'h1);
    checkOutput("bp words", 32'(words),       32'h4);
    applyStimulus(4'b0000, 1'b1);

    // Owner withdraws its request after the second read.
    pulseReset();
    fifoFlush();
    for (int i = 0; i < 4; i++) pushWord(8'h50 + 8'(i));
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("drop r1 gnt",   32'(gnt),        32'h2);
    checkOutput("drop r1 rd_en", 32'(fifo_rd_en), 32'h1);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("drop r2 rd_en", 32'(fifo_rd_en), 32'h1);
    checkOutput("drop r2 data",  32'(out_data),   32'h50);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("drop r3 rd_en", 32'(fifo_rd_en), 32'h0);
    checkOutput("drop r3 valid", 32'(out_valid),  32'h1);
    checkOutput("drop r3 data",  32'(out_data),   32'h51);
    checkOutput("drop r3 id",    32'(out_id),     32'h1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("drop r4 rd_en", 32'(fifo_rd_en),  32'h0);
    checkOutput("drop r4 valid", 32'(out_valid),   32'h0);
    checkOutput("drop r4 done",  32'(burst_done),  32'h1);
    checkOutput("drop r4 abort", 32'(burst_abort), 32'h1);
    checkOutput("drop r4 last",  32'(out_last),    32'h0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("drop r5 gnt",   32'(gnt),         32'h0);

    // Reset lands the cycle after a read: that word is lost.
    pulseReset();
    fifoFlush();
    for (int i = 0; i < 4; i++) pushWord(8'h60 + 8'(i));
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("rst gnt before", 32'(gnt),        32'h4);
    checkOutput("rst rd_en",      32'(fifo_rd_en), 32'h1);
    @(posedge rclk);
    #1;
    rrst_n = 1'b0;
    @(negedge rclk);
    #1;
    checkIdleZero("in reset a");
    @(negedge rclk);
    #1;
    checkIdleZero("in reset b");
    rrst_n = 1'b1;
    req    = 4'b1111;
    watchBurst("restart", 4'b0001, 0, 3, 8'h61, 1'b1, 20);
    req = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
